// File: rtl/decim_pkg.sv
// Shared definitions for the decimation stages: mode encodings,
// default widths and the accumulator width rule.
package decim_pkg;

    typedef enum logic {
        MODE_SAMPLE = 1'b0,
        MODE_AVG    = 1'b1
    } mode_e;

    localparam int DEFAULT_DATA_W   = 12;
    localparam int DEFAULT_MAX_LOG2 = 9;

    // A frame of 2^max_log2 full-scale samples needs max_log2 extra bits.
    function automatic int acc_width(input int data_w, input int max_log2);
        return data_w + max_log2;
    endfunction

endpackage

// File: rtl/decim_out_reg.sv
// One-entry output holding register with valid/ready handshake and a
// sticky overrun flag that records results overwritten before use.
module decim_out_reg #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              clr_overrun
);

    logic [DATA_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              overrun_reg, overrun_next;
    logic              overrun_set;

    // Next-state for data, valid and overrun; a new result always wins.
    always_comb begin
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        overrun_set  = load && valid_reg && !out_ready;

        if (load) begin
            data_next  = load_data;
            valid_next = 1'b1;
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end

        // Set takes priority over a simultaneous clear.
        if (overrun_set) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign data_out  = data_reg;
    assign out_valid = valid_reg;
    assign overrun   = overrun_reg;

endmodule

// File: rtl/decim_avg.sv
// Power-of-two decimator: per frame of 2^L accepted samples, emits either
// the last sample or the truncated boxcar average of the frame.
module decim_avg
    import decim_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int MAX_LOG2 = DEFAULT_MAX_LOG2,
    // Must satisfy 2^LOG2_W > MAX_LOG2 so the clamp value is representable.
    parameter int LOG2_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic [LOG2_W-1:0] ratio_log2,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int ACC_W = acc_width(DATA_W, MAX_LOG2);

    logic                accept;
    logic                first_sample;
    logic                frame_last;
    logic                result_load;
    mode_e               mode_reg;
    mode_e               eff_mode;
    logic [LOG2_W-1:0]   ratio_reg;
    logic [LOG2_W-1:0]   ratio_clamped;
    logic [LOG2_W-1:0]   eff_ratio;
    logic [MAX_LOG2-1:0] cnt_reg, cnt_next;
    logic [MAX_LOG2-1:0] last_mask;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic [ACC_W-1:0]    sum;
    logic [DATA_W-1:0]   avg_result;
    logic [DATA_W-1:0]   result;

    assign accept        = enable && in_valid;
    assign first_sample  = (cnt_reg == '0);
    assign ratio_clamped = (ratio_log2 > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : ratio_log2;

    // The first sample of a frame sees the live config, later ones the latched copy.
    assign eff_mode  = first_sample ? mode_e'(mode) : mode_reg;
    assign eff_ratio = first_sample ? ratio_clamped : ratio_reg;

    // Terminal count N-1 is a mask of L low ones.
    generate
        for (genvar gi = 0; gi < MAX_LOG2; gi++) begin : g_last_mask
            assign last_mask[gi] = (eff_ratio > LOG2_W'(gi));
        end
    endgenerate

    assign frame_last  = (cnt_reg == last_mask);
    assign result_load = accept && frame_last;

    // Running sum including the current sample, and the truncated average.
    always_comb begin
        sum        = (first_sample ? '0 : acc_reg) + ACC_W'(data_in);
        avg_result = DATA_W'(sum >> eff_ratio);
        result     = (eff_mode == MODE_AVG) ? avg_result : data_in;
    end

    // Counter and accumulator next-state; disable discards the partial frame.
    always_comb begin
        cnt_next = cnt_reg;
        acc_next = acc_reg;
        if (!enable) begin
            cnt_next = '0;
            acc_next = '0;
        end else if (accept) begin
            if (frame_last) begin
                cnt_next = '0;
                acc_next = '0;
            end else begin
                cnt_next = cnt_reg + MAX_LOG2'(1);
                acc_next = sum;
            end
        end
    end

    // Frame state and per-frame config latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mode_reg  <= MODE_SAMPLE;
            ratio_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            acc_reg <= acc_next;
            if (accept && first_sample) begin
                mode_reg  <= mode_e'(mode);
                ratio_reg <= ratio_clamped;
            end
        end
    end

    decim_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (result_load),
        .load_data   (result),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

endmodule

// File: tb/tb_decim_avg.sv
// Self-checking bench for decim_avg: a behavioural frame model pushes
// expected results (value and arrival cycle) into a scoreboard that a
// negedge monitor pops; handshake and reset corners are checked directly.
module tb_decim_avg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        mode;
    logic [3:0]  ratio_log2;
    logic        in_valid;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        clr_overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int q_data[$];
    int q_cyc[$];
    bit sb_en = 1'b0;

    // Independent frame model
    int m_cnt  = 0;
    int m_acc  = 0;
    int m_l    = 0;
    int m_mode = 0;

    bit prev_v = 1'b0;
    bit prev_r = 1'b0;

    decim_avg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .ratio_log2  (ratio_log2),
        .in_valid    (in_valid),
        .data_in     (data_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, obs, cyc);
        end
    endtask

    // One clock of stimulus; the model runs on the same inputs.
    task automatic step(input bit en, input bit iv, input int d);
        int res;
        enable   = en;
        in_valid = iv;
        data_in  = d[11:0];
        if (!en) begin
            m_cnt = 0;
            m_acc = 0;
        end else if (iv) begin
            if (m_cnt == 0) begin
                m_l    = (ratio_log2 > 4'd9) ? 9 : int'(ratio_log2);
                m_mode = int'(mode);
                m_acc  = 0;
            end
            m_acc = m_acc + d;
            m_cnt = m_cnt + 1;
            if (m_cnt == (1 << m_l)) begin
                res   = (m_mode == 1) ? (m_acc >> m_l) : d;
                m_cnt = 0;
                if (sb_en) begin
                    q_data.push_back(res);
                    q_cyc.push_back(cyc + 1);
                end
            end
        end
        @(posedge clk);
        #1;
        clr_overrun = 1'b0;
    endtask

    // Monitor: a fresh result is one not already seen in the previous cycle.
    always @(negedge clk) begin
        if (rst_n && sb_en && out_valid && (!prev_v || prev_r)) begin
            if (q_data.size() == 0) begin
                chk("sb_unexpected_out", int'(data_out), -1);
            end else begin
                chk("sb_data", int'(data_out), q_data.pop_front());
                chk("sb_latency", cyc, q_cyc.pop_front());
            end
        end
        prev_v = out_valid;
        prev_r = out_ready;
    end

    initial begin
        int acc_n;
        int bit_t;
        rst_n       = 1'b0;
        enable      = 1'b0;
        mode        = 1'b0;
        ratio_log2  = 4'd0;
        in_valid    = 1'b0;
        data_in     = '0;
        out_ready   = 1'b1;
        clr_overrun = 1'b0;

        #2;
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_en = 1'b1;

        // Legacy 512:1 sample-and-hold
        mode = 1'b0; ratio_log2 = 4'd9;
        for (int i = 0; i < 1024; i++) step(1, 1, i % 4096);
        step(1, 0, 0);

        // Averaging L=2: 10,11,12,14 -> 11
        mode = 1'b1; ratio_log2 = 4'd2;
        step(1, 1, 10); step(1, 1, 11); step(1, 1, 12); step(1, 1, 14);
        chk("avg_l2", int'(data_out), 11);
        step(1, 0, 0);

        // Full scale L=9
        ratio_log2 = 4'd9;
        for (int i = 0; i < 512; i++) step(1, 1, 4095);
        chk("avg_full_scale", int'(data_out), 4095);
        step(1, 0, 0);

        // Gapped input, ratio change mid-frame
        ratio_log2 = 4'd3;
        acc_n = 0;
        for (int i = 0; acc_n < 10; i++) begin
            bit_t = i % 2;
            if (acc_n == 3) ratio_log2 = 4'd1;
            step(1, bit_t[0], $urandom_range(0, 4095));
            if (bit_t == 1) acc_n++;
        end
        step(1, 0, 0);
        step(1, 0, 0);

        // Backpressure, L=0
        sb_en = 1'b0;
        mode = 1'b0; ratio_log2 = 4'd0; out_ready = 1'b0;
        step(1, 1, 5); step(1, 1, 6); step(1, 1, 7);
        chk("bp_data", int'(data_out), 7);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_overrun", int'(overrun), 1);
        out_ready = 1'b1;
        step(1, 0, 0);
        out_ready = 1'b0;
        chk("bp_consume_valid", int'(out_valid), 0);
        chk("bp_overrun_sticky", int'(overrun), 1);
        clr_overrun = 1'b1;
        step(1, 0, 0);
        chk("bp_clr", int'(overrun), 0);
        step(1, 1, 8);
        chk("bp_load_empty_no_ovr", int'(overrun), 0);
        clr_overrun = 1'b1;
        step(1, 1, 9);
        chk("bp_set_beats_clr", int'(overrun), 1);
        chk("bp_overwrite_data", int'(data_out), 9);
        clr_overrun = 1'b1;
        step(1, 0, 0);
        out_ready = 1'b1;
        step(1, 1, 10);
        chk("bp_consume_and_load_valid", int'(out_valid), 1);
        chk("bp_consume_and_load_data", int'(data_out), 10);
        chk("bp_consume_and_load_no_ovr", int'(overrun), 0);
        step(1, 0, 0);
        chk("bp_drained", int'(out_valid), 0);
        sb_en = 1'b1;

        // Abort with enable low
        mode = 1'b1; ratio_log2 = 4'd2;
        step(1, 1, 1000); step(1, 1, 2000);
        step(0, 1, 3000);
        step(1, 1, 100); step(1, 1, 200); step(1, 1, 301); step(1, 1, 400);
        chk("abort_avg", int'(data_out), 250);
        step(1, 0, 0);

        // Asynchronous reset mid-frame
        sb_en = 1'b0;
        out_ready = 1'b0; ratio_log2 = 4'd0;
        step(1, 1, 33); step(1, 1, 34);
        ratio_log2 = 4'd2;
        step(1, 1, 500); step(1, 1, 600);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", int'(data_out), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_overrun", int'(overrun), 0);
        m_cnt = 0;
        m_acc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(1, 0, 0);
        sb_en = 1'b1;
        step(1, 1, 40); step(1, 1, 41); step(1, 1, 42); step(1, 1, 45);
        step(1, 0, 0);

        // Clamp: ratio 15 behaves as 9
        mode = 1'b0; ratio_log2 = 4'd15;
        for (int i = 0; i < 1024; i++) step(1, 1, (i * 7) % 4096);
        step(1, 0, 0);
        step(1, 0, 0);

        chk("sb_drained", q_data.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decim_avg.md
Name: decim_avg

Overview:
- Parametrised successor to the fixed 512:1 sample-and-hold decimator.
- Sits between the modulator's reconstruction path and downstream readout logic.
- Decimates an unsigned sample stream by a runtime-selectable power-of-two ratio.
- Two modes: pick the last sample of each frame, or boxcar-average the frame.
- Output is held in a one-entry register with a valid/ready handshake and a sticky overrun flag.

Parameters:
- DATA_W, 12: width of input and output samples (unsigned).
- MAX_LOG2, 9: largest supported log2 ratio; 9 gives 512:1, the legacy ratio.
- LOG2_W, 4: width of the ratio_log2 port; must satisfy 2^LOG2_W > MAX_LOG2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low aborts the current frame.
- mode  in  1  0 = sample (last of frame), 1 = average.
- ratio_log2  in  LOG2_W  log2 of the decimation ratio N.
- in_valid  in  1  data_in is valid this cycle.
- data_in  in  DATA_W  input sample, unsigned.
- data_out  out  DATA_W  decimated result, unsigned.
- out_valid  out  1  data_out holds an unconsumed result.
- out_ready  in  1  consumer accepts data_out when out_valid && out_ready.
- overrun  out  1  sticky: a result was overwritten before it was consumed.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low. Asserting rst_n low clears all state immediately:
  - data_out=0, out_valid=0, overrun=0.
  - Sample counter=0, accumulator=0, latched config=0.
- Accept: a sample is accepted on a cycle where enable && in_valid.
- Config latch: mode and ratio_log2 are captured on the first accepted sample of each frame (counter==0).
  - Changes mid-frame take effect at the next frame.
  - ratio_log2 > MAX_LOG2 is clamped to MAX_LOG2.
- Frame length: N = 2^L, where L is the latched ratio. The counter is MAX_LOG2 bits wide and counts accepted samples 0..N-1.
  - The accepted sample with counter==N-1 closes the frame; the counter then wraps to 0.
- Accumulator: width DATA_W+MAX_LOG2; it cannot overflow at any ratio.
  - The first sample of a frame loads the accumulator; later samples add to it.
- Result computation:
  - Mode 0: result = the closing sample.
  - Mode 1: result = (accumulator + closing sample) >> L, truncating. No rounding.
- Result latency:
  - The result is registered into data_out at the clock edge that accepts the closing sample.
  - out_valid rises on that same edge, so the result is visible the cycle after the closing in_valid.
- L=0: every accepted sample is passed through one cycle later, in both modes.
- Handshake:
  - If out_valid && out_ready and no new result is produced, out_valid falls next edge.
  - If out_valid && out_ready and a new result is produced the same cycle, data_out loads the new result and out_valid stays 1. No overrun is flagged.
  - If out_valid && !out_ready and a new result is produced, data_out is overwritten with the newest result and overrun is set.
  - data_out is stable while out_valid && !out_ready and no new result arrives.
- overrun:
  - Cleared by clr_overrun.
  - If a set condition and clr_overrun occur in the same cycle, set wins.
- enable low:
  - Counter and accumulator are synchronously zeroed; the partial frame is discarded.
  - in_valid is ignored.
  - data_out, out_valid and overrun are retained, and the handshake still operates.
- in_valid gaps: idle cycles mid-frame do not advance the counter. The ratio counts samples, not clocks.
- Reset mid-frame: the partial frame is discarded and no result is emitted.

Decomposition:
- Shared package decim_pkg:
  - Mode encodings MODE_SAMPLE=0, MODE_AVG=1.
  - Default DATA_W and MAX_LOG2.
  - A helper function for accumulator width.
- One natural sub-module, decim_out_reg: the one-entry output holding register with the valid/ready handshake and overrun logic. It is reusable by the other decimation stages.
- Counter, config latch and accumulator stay in decim_avg.

Test Plan:
- Legacy equivalence: mode=0, ratio_log2=9, in_valid=1 every cycle, data_in = sample index mod 4096, out_ready=1.
  - Required: out_valid pulses every 512 cycles.
  - data_out = 511, 1023, ...; each pulse arrives one cycle after the closing sample.
- Averaging: mode=1, L=2, samples 10, 11, 12, 14.
  - Required: data_out=11 (47>>2, truncated).
  - Full-scale check: L=9 with all samples 4095 gives 4095, with no overflow.
- Gapped input and mid-frame config change: L=3 with in_valid toggling 50%.
  - Required: a result after exactly 8 accepted samples.
  - Changing ratio_log2 to 1 mid-frame leaves that frame at 8; the next frame is 2 samples.
- Backpressure: L=0, out_ready=0, three samples 5, 6, 7.
  - Required: data_out=7, out_valid=1, overrun=1.
  - Then out_ready=1 for one cycle drops out_valid.
  - clr_overrun together with a new overwrite leaves overrun=1.
- Abort and reset: L=2, two samples accepted, then enable low for one cycle, then 4 more samples.
  - Required: the result is the average of the 4 new samples only.
  - Asserting rst_n low mid-frame clears all outputs asynchronously, before the next clock edge.
- Clamp: ratio_log2=15.
  - Required: behaves as L=9, i.e. a result every 512 samples.
